axi_lite_rd_master: RTL

//  AXI4-Lite read initiator: accepts a (start address, word count) command and issues
//  one single-beat AR/R transaction per word toward an AXI4-Lite read-only slave (ROM, CSR bank).

---
 rtl/axi_lite_rd_master_if.sv | 50 +++++
 rtl/axi_lite_rd_master.sv | 126 ++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_master_if.sv
// Bus bundle for axi_lite_rd_master: command input, AXI4-Lite read
// channels and the returned-word stream, with master/slave views.
interface axi_lite_rd_master_if #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH      = 8
);
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]      cmd_len_i;
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;

  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  logic [AXI_DATA_WIDTH-1:0] data_o;
  logic                      data_valid_o;
  logic                      data_ready_i;
  logic                      data_last_o;

  logic                      busy_o;
  logic                      done_o;
  logic                      err_o;

  modport master (
    input  cmd_addr_i, cmd_len_i, cmd_valid_i,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  data_ready_i,
    output cmd_ready_o,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    output data_o, data_valid_o, data_last_o,
    output busy_o, done_o, err_o
  );

  modport slave (
    output cmd_addr_i, cmd_len_i, cmd_valid_i,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output data_ready_i,
    input  cmd_ready_o,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    input  data_o, data_valid_o, data_last_o,
    input  busy_o, done_o, err_o
  );
endinterface

// File: rtl/axi_lite_rd_master.sv
// AXI4-Lite read initiator: turns a (start address, word count) command into
// one single-beat AR/R transaction per word, forwarding each word on a
// valid/ready stream. One transaction outstanding at a time.
module axi_lite_rd_master #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH      = 8
) (
  input logic                  axi_clk,
  input logic                  axi_rst_n,
  axi_lite_rd_master_if.master bus
);

  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      last_q, last_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      last_q      <= last_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath updates for the IDLE -> AR -> R -> OUT sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    last_d      = last_q;
    err_d       = err_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          addr_d      = bus.cmd_addr_i;
          remaining_d = bus.cmd_len_i;
          err_d       = 1'b0;
          if (bus.cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_AR;
          end
        end
      end

      ST_AR: begin
        if (bus.m_axi_arready) begin
          state_d = ST_R;
        end
      end

      ST_R: begin
        if (bus.m_axi_rvalid) begin
          data_d  = bus.m_axi_rdata;
          last_d  = (remaining_q == LEN_WIDTH'(1));
          state_d = ST_OUT;
          if (bus.m_axi_rresp != 2'b00) begin
            err_d = 1'b1;
          end
        end
      end

      ST_OUT: begin
        if (bus.data_ready_i) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          addr_d      = addr_q + ADDR_STEP;
          if (last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_AR;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only, so they never
  // depend combinationally on the far side's inputs.
  always_comb begin
    bus.cmd_ready_o   = (state_q == ST_IDLE);
    bus.busy_o        = (state_q != ST_IDLE);
    bus.m_axi_arvalid = (state_q == ST_AR);
    bus.m_axi_araddr  = addr_q;
    bus.m_axi_arprot  = 3'b000;
    bus.m_axi_rready  = (state_q == ST_R);
    bus.data_valid_o  = (state_q == ST_OUT);
    bus.data_o        = data_q;
    bus.data_last_o   = last_q & (state_q == ST_OUT);
    bus.done_o        = done_q;
    bus.err_o         = err_q;
  end

endmodule
